// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package mul_div_unit_pkg;

   localparam int unsigned MDU_WIDTH = 32;
   localparam int unsigned MDU_CNT_W = $clog2(MDU_WIDTH + 1);

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } mdu_state_e;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return op[0];
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Working registers for one radix-2 shift-add multiply or restoring divide step per enable.
module mdu_datapath #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] b_q;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;

   // hi is the partial product / remainder, lo the multiplier / quotient shift register
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      div_shift = {hi, lo[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, b_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi  <= '0;
         lo  <= '0;
         b_q <= '0;
      end else if (load) begin
         hi  <= '0;
         lo  <= opa;
         b_q <= opb;
      end else if (step) begin
         if (is_div) begin
            if (!div_diff[WIDTH+1]) begin
               hi <= div_diff[WIDTH-1:0];
               lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
               hi <= div_shift[WIDTH-1:0];
               lo <= {lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             hiWe,
   input  logic             loWe,
   input  logic [WIDTH-1:0] writeData,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   mdu_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] src1_q;
   logic             neg_q;
   logic             neg_r;
   logic             div0_q;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] dp_hi, dp_lo;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] hi_n, lo_n;

   // Operand magnitudes at launch; the most-negative value maps to its own unsigned magnitude
   always_comb begin
      a_neg = op_is_signed(op) & src1[WIDTH-1];
      b_neg = op_is_signed(op) & src2[WIDTH-1];
      a_mag = a_neg ? WIDTH'(-src1) : src1;
      b_mag = b_neg ? WIDTH'(-src2) : src2;
   end

   mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk    (clk),
      .rst    (rst),
      .load   ((state == ST_IDLE) && start),
      .step   (state == ST_CALC),
      .is_div (op_is_div(op_q)),
      .opa    (a_mag),
      .opb    (b_mag),
      .hi     (dp_hi),
      .lo     (dp_lo)
   );

   // Sign fix-up and divide-by-zero override applied on the FIX edge
   always_comb begin
      prod = {dp_hi, dp_lo};
      if (neg_q) prod = (2*WIDTH)'(-prod);
      if (!op_is_div(op_q)) begin
         hi_n = prod[2*WIDTH-1:WIDTH];
         lo_n = prod[WIDTH-1:0];
      end else if (div0_q) begin
         hi_n = src1_q;
         lo_n = '1;
      end else begin
         hi_n = neg_r ? WIDTH'(-dp_hi) : dp_hi;
         lo_n = neg_q ? WIDTH'(-dp_lo) : dp_lo;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         op_q   <= '0;
         src1_q <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0_q <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state  <= ST_CALC;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  op_q   <= op;
                  src1_q <= src1;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  div0_q <= (src2 == '0);
               end else begin
                  if (hiWe) hi <= writeData;
                  if (loWe) lo <= writeData;
               end
            end
            ST_CALC: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
            end
            ST_FIX: begin
               hi    <= hi_n;
               lo    <= lo_n;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with WIDTH = 32.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src1, src2;
   logic        hiWe, loWe;
   logic [31:0] writeData;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_err = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .src1      (src1),
      .src2      (src2),
      .hiWe      (hiWe),
      .loWe      (loWe),
      .writeData (writeData),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   // Pulse start for one edge; returns at the falling edge just after E0
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; src1 = a; src2 = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Count falling edges with busy high (bounded); report done where busy drops
   task automatic wait_idle(output int n, output logic d);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      d = done;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
      hiWe = 1'b0; loWe = 1'b0; writeData = '0;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
      n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
      rst = 1'b0;
   endtask

   task automatic test_multu_max;
      int n; logic d;
      launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(n, d);
      n_cmp++; if (n !== 33) begin n_err++; $display("FAIL multu_busy_cycles got %0d want 33", n); end
      n_cmp++; if (d !== 1'b1) begin n_err++; $display("FAIL multu_done got %b want 1", d); end
      n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got %h want fffffffe", hi); end
      n_cmp++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got %h want 00000001", lo); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL multu_done_pulse got %b want 0", done); end
   endtask

   task automatic test_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n; logic d;
      launch(o, a, b);
      wait_idle(n, d);
      n_cmp++; if (n !== 33 || d !== 1'b1) begin n_err++; $display("FAIL %s_timing got busy=%0d done=%b want 33/1", name, n, d); end
      n_cmp++; if (hi !== exp_hi) begin n_err++; $display("FAIL %s_hi got %h want %h", name, hi, exp_hi); end
      n_cmp++; if (lo !== exp_lo) begin n_err++; $display("FAIL %s_lo got %h want %h", name, lo, exp_lo); end
   endtask

   task automatic test_back_to_back;
      int n; logic d;
      launch(2'b00, 32'd3, 32'd4);
      wait_idle(n, d);
      n_cmp++; if (d !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got %b want 1", d); end
      start = 1'b1; op = 2'b10; src1 = 32'd100; src2 = 32'd7;
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
      n_cmp++; if (hi !== 32'h0 || lo !== 32'd12) begin n_err++; $display("FAIL b2b_hold got %h/%h want 0/0000000c", hi, lo); end
      wait_idle(n, d);
      n_cmp++; if (n !== 33 || d !== 1'b1) begin n_err++; $display("FAIL b2b_second_timing got busy=%0d done=%b want 33/1", n, d); end
      n_cmp++; if (hi !== 32'd2 || lo !== 32'd14) begin n_err++; $display("FAIL b2b_second got %h/%h want 2/e", hi, lo); end
   endtask

   task automatic test_busy_ignore;
      int n; logic d;
      launch(2'b00, 32'd6, 32'd7);
      repeat (4) @(negedge clk);
      n_cmp++; if (hi !== 32'd2 || lo !== 32'd14) begin n_err++; $display("FAIL busy_hold got %h/%h want 2/e", hi, lo); end
      start = 1'b1; op = 2'b11; src1 = 32'd9; src2 = 32'd3;
      hiWe = 1'b1; loWe = 1'b1; writeData = 32'h0000_FFFF;
      @(negedge clk);
      start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
      n_cmp++; if (hi !== 32'd2 || lo !== 32'd14) begin n_err++; $display("FAIL busy_mt_ignored got %h/%h want 2/e", hi, lo); end
      wait_idle(n, d);
      n_cmp++; if (n >= 100 || d !== 1'b1) begin n_err++; $display("FAIL busy_ignore_done got busy=%0d done=%b want <100/1", n, d); end
      n_cmp++; if (hi !== 32'h0 || lo !== 32'd42) begin n_err++; $display("FAIL busy_ignore_result got %h/%h want 0/2a", hi, lo); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_second_start_dropped got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid;
      int seen;
      launch(2'b11, 32'd100, 32'd3);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_mid_flags got busy=%b done=%b want 0/0", busy, done); end
      n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL rst_mid_hilo got %h/%h want 0/0", hi, lo); end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d active cycles want 0", seen); end
   endtask

   task automatic test_mthi_mtlo;
      int n; logic d;
      @(negedge clk);
      hiWe = 1'b1; writeData = 32'h0000_AAAA;
      @(negedge clk);
      hiWe = 1'b0;
      n_cmp++; if (hi !== 32'h0000_AAAA || lo !== 32'h0) begin n_err++; $display("FAIL mthi got %h/%h want aaaa/0", hi, lo); end
      hiWe = 1'b1; loWe = 1'b1; writeData = 32'h0000_5555;
      @(negedge clk);
      hiWe = 1'b0; loWe = 1'b0;
      n_cmp++; if (hi !== 32'h0000_5555 || lo !== 32'h0000_5555) begin n_err++; $display("FAIL mthi_mtlo_both got %h/%h want 5555/5555", hi, lo); end
      start = 1'b1; op = 2'b00; src1 = 32'd2; src2 = 32'd3;
      loWe = 1'b1; writeData = 32'h0000_DEAD;
      @(negedge clk);
      start = 1'b0; loWe = 1'b0;
      n_cmp++; if (lo !== 32'h0000_5555) begin n_err++; $display("FAIL start_wins_mtlo got %h want 5555", lo); end
      wait_idle(n, d);
      n_cmp++; if (d !== 1'b1 || hi !== 32'h0 || lo !== 32'd6) begin n_err++; $display("FAIL start_wins_result got done=%b %h/%h want 1 0/6", d, hi, lo); end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
      test_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
      test_op("divu",      2'b10, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E);
      test_op("divu_zero", 2'b10, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF);
      test_op("div_zero",  2'b11, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
      test_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      test_op("mult_pos",  2'b01, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_000E);
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      test_mthi_mtlo();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core. It sits beside the ALU, downstream of the register pile: it takes rs/rt data and a control-unit opcode, runs a multi-cycle shift-add or shift-subtract sequence, and holds the 64-bit result in HI/LO for MFHI/MFLO. A `busy` output lets the control unit stall the PC while an operation is in flight.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  launch an operation; sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `src1`  in  WIDTH  rs data; multiplicand or dividend.
- `src2`  in  WIDTH  rt data; multiplier or divisor.
- `hiWe`  in  1  MTHI strobe.
- `loWe`  in  1  MTLO strobe.
- `writeData`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states and transitions:
  - IDLE: on `start`, go to CALC.
  - CALC: runs exactly `WIDTH` iterations, then goes to FIX.
  - FIX: goes to IDLE.
- On `start`, the unit latches `op`, `src1` and `src2`. Later input changes do not affect the result.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at launch.
  - Result signs are applied in FIX.
  - MULT: the product is negated if the operand signs differ.
  - DIV: the quotient sign is the XOR of the operand signs. The remainder sign follows the dividend.
- Multiply:
  - Radix-2 shift-add, one multiplier bit per CALC cycle.
  - In FIX: HI = product[2W-1:W], LO = product[W-1:0].
- Divide:
  - Restoring shift-subtract, one quotient bit per CALC cycle.
  - In FIX: LO = quotient, HI = remainder.
- Divide by zero (DIVU or DIV): takes the normal latency. Result is LO = all ones, HI = `src1` unmodified.
- DIV overflow (most-negative / −1): LO = 0x80000000, HI = 0, i.e. natural wrap, with no trap.
- MTHI/MTLO:
  - In IDLE with `start` low, `hiWe`/`loWe` write `writeData` into HI/LO on the next edge. Both strobes may be active in the same cycle.
  - If `start` is asserted in the same cycle, `start` wins and the writes are dropped.
- Input handling while busy:
  - `start` while not IDLE is ignored.
  - `hiWe`/`loWe` while not IDLE are ignored.
- Reset, including mid-operation, returns the unit to IDLE:
  - HI = 0, LO = 0, `busy` = 0, `done` = 0.
  - The iteration counter and working registers are cleared.

## Timing
- Reset values: `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0; the state is IDLE.
- `start` is sampled on edge E0. `busy` is 1 from after E0 until after E(WIDTH+1).
- CALC iterations occur on edges E1 through E(WIDTH).
- FIX is the cycle after E(WIDTH). On edge E(WIDTH+1):
  - HI/LO update.
  - `done` goes to 1 for exactly one cycle.
  - `busy` returns to 0.
- Total latency from `start` to the result being visible is WIDTH+1 edges (33 for WIDTH = 32).
- A new `start` is accepted in the cycle `done` is high, so back-to-back spacing is WIDTH+2 cycles.
- `busy` is a registered output, with no combinational path from `start`. The control unit stalls on `start | busy`.
- `hi`/`lo` are registered. They keep the previous result throughout an operation.

## Structure
- Shared package:
  - `op` encodings (MULTU, MULT, DIVU, DIV).
  - FSM state typedef (IDLE, CALC, FIX).
  - Counter width constant, `$clog2(WIDTH+1)`.
- Control-unit opcode decode to `op`/`start`/`hiWe`/`loWe` lives in the control unit, not here.
- One sub-module, `mdu_datapath`: holds the working registers and computes one shift-add/shift-subtract step per enable. The top level holds the FSM, counter, sign handling and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles, `done` pulses. HI = 0xFFFFFFFE, LO = 0x00000001. `busy` is high for exactly 33 cycles.
- MULT −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- DIV −7 ÷ 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 ÷ 7 → LO = 0x0000000E, HI = 0x00000002.
- DIVU 0x1234 ÷ 0 → LO = 0xFFFFFFFF, HI = 0x00001234.
- Second `start` 5 cycles into a MULTU is ignored and the first result is intact. Then `rst` pulsed at cycle 10 of a new DIV → `busy` = 0, HI = LO = 0 immediately, no `done`. Then MTHI 0xAAAA with `start` low in IDLE → HI = 0xAAAA next cycle.
